// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared IO map constants and the status-byte packer.
// Optional RX path is selected by the MEM_RESPONDER_RX_EN macro.
package mem_responder_pkg;

   // Decoded (18-bit) addresses of the IO registers and the IO region select
   localparam logic [17:0] IO_DATA = 18'h30000;
   localparam logic [17:0] IO_STAT = 18'h30004;
   localparam logic [1:0]  IO_SEL  = 2'b11;

   // Status register layout: {5'b0, tx_ovf, rx_nonempty, io_buffer_full}
   function automatic logic [7:0] pack_status(input logic tx_ovf,
                                              input logic rx_nonempty,
                                              input logic io_full);
      return {5'b00000, tx_ovf, rx_nonempty, io_full};
   endfunction

endpackage

// File: rtl/mem_responder_byte_fifo.sv
// mem_responder_byte_fifo: byte-wide FIFO of 2^DEPTH_LOG entries with
// occupancy count. A push into a full FIFO is accepted when a pop happens
// on the same edge. Reset empties it asynchronously; storage is not reset.
module mem_responder_byte_fifo #(
   parameter int DEPTH_LOG = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [7:0]           wdata,
   output logic [7:0]           rdata,
   output logic                 full,
   output logic                 empty,
   output logic [DEPTH_LOG:0]   count
);

   localparam int                DEPTH   = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] DEPTH_C = DEPTH[DEPTH_LOG:0];

   logic [7:0]           mem_r [0:DEPTH-1];
   logic [DEPTH_LOG-1:0] wr_ptr_r;
   logic [DEPTH_LOG-1:0] rd_ptr_r;
   logic [DEPTH_LOG:0]   count_r;
   logic                 push_ok_s;
   logic                 pop_ok_s;

   assign full      = (count_r == DEPTH_C);
   assign empty     = (count_r == {(DEPTH_LOG+1){1'b0}});
   assign count     = count_r;
   assign rdata     = mem_r[rd_ptr_r];
   assign pop_ok_s  = pop && !empty;
   assign push_ok_s = push && (!full || pop_ok_s);

   // Storage write; contents deliberately left out of reset
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointers wrap naturally at the pointer width; count tracks occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {DEPTH_LOG{1'b0}};
         rd_ptr_r <= {DEPTH_LOG{1'b0}};
         count_r  <= {(DEPTH_LOG+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte RAM plus a memory-mapped TX/RX byte port.
// IO region is bus_addr[17:16]==2'b11: 0x30000 data, 0x30004 status.
// Define MEM_RESPONDER_RX_EN to build the RX FIFO path; without it the
// RX side is inert (rx_ready=0, data reads return 0).
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W       = 17,
   parameter int TX_DEPTH_LOG = 3,
   parameter int RX_DEPTH_LOG = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [31:0] bus_addr,
   input  logic        bus_wr,
   input  logic [7:0]  bus_wdata,
   output logic [7:0]  bus_rdata,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int                   TX_DEPTH  = 1 << TX_DEPTH_LOG;
   localparam int                   TX_MARK_I = TX_DEPTH - 1;
   localparam logic [TX_DEPTH_LOG:0] TX_MARK  = TX_MARK_I[TX_DEPTH_LOG:0];

   logic [7:0]          ram_r [0:(1<<ADDR_W)-1];
   logic [17:0]         addr_s;
   logic [ADDR_W-1:0]   ram_idx_s;
   logic                is_io_s;
   logic                is_data_s;
   logic                is_stat_s;
   logic                wr_cyc_s;
   logic                rd_cyc_s;
   logic                tx_push_s;
   logic                tx_pop_s;
   logic                tx_full_s;
   logic                tx_empty_s;
   logic                tx_drop_s;
   logic [TX_DEPTH_LOG:0] tx_count_s;
   logic                tx_ovf_r;
   logic                rx_nonempty_s;
   logic [7:0]          rx_head_s;
   logic [7:0]          rd_next_s;
   logic                addr_unused_s;

   assign addr_s        = bus_addr[17:0];
   assign addr_unused_s = ^bus_addr[31:18];
   assign ram_idx_s     = bus_addr[ADDR_W-1:0];
   assign is_io_s       = (addr_s[17:16] == IO_SEL);
   assign is_data_s     = is_io_s && (addr_s == IO_DATA);
   assign is_stat_s     = is_io_s && (addr_s == IO_STAT);
   assign wr_cyc_s      = rdy && bus_wr;
   assign rd_cyc_s      = rdy && !bus_wr;

   // TX side: the sink drains the head; initiator writes to IO_DATA push
   assign tx_valid       = !tx_empty_s;
   assign tx_pop_s       = rdy && tx_valid && tx_ready;
   assign tx_push_s      = wr_cyc_s && is_data_s;
   assign tx_drop_s      = tx_push_s && tx_full_s && !tx_pop_s;
   assign io_buffer_full = (tx_count_s >= TX_MARK);

   mem_responder_byte_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push_s),
      .pop   (tx_pop_s),
      .wdata (bus_wdata),
      .rdata (tx_data),
      .full  (tx_full_s),
      .empty (tx_empty_s),
      .count (tx_count_s)
   );

`ifdef MEM_RESPONDER_RX_EN
   logic                  rx_push_s;
   logic                  rx_pop_s;
   logic                  rx_full_s;
   logic                  rx_empty_s;
   logic [7:0]            rx_fifo_data_s;
   logic [RX_DEPTH_LOG:0] rx_count_unused_s;

   // Data reads of IO_DATA pop the RX head only when something is queued
   assign rx_ready      = !rx_full_s;
   assign rx_push_s     = rdy && rx_valid && rx_ready;
   assign rx_pop_s      = rd_cyc_s && is_data_s && !rx_empty_s;
   assign rx_nonempty_s = !rx_empty_s;
   assign rx_head_s     = rx_empty_s ? 8'h00 : rx_fifo_data_s;

   mem_responder_byte_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push_s),
      .pop   (rx_pop_s),
      .wdata (rx_data),
      .rdata (rx_fifo_data_s),
      .full  (rx_full_s),
      .empty (rx_empty_s),
      .count (rx_count_unused_s)
   );
`else
   localparam int RX_DEPTH_UNUSED = RX_DEPTH_LOG;
   logic          rx_unused_s;

   assign rx_unused_s   = ^{rx_data, rx_valid};
   assign rx_ready      = 1'b0;
   assign rx_nonempty_s = 1'b0;
   assign rx_head_s     = 8'h00;
`endif

   // RAM write port; RAM contents survive reset
   always_ff @(posedge clk) begin
      if (wr_cyc_s && !is_io_s) begin
         ram_r[ram_idx_s] <= bus_wdata;
      end
   end

   // Select the byte a read cycle would return
   always_comb begin
      rd_next_s = 8'h00;
      if (!is_io_s) begin
         rd_next_s = ram_r[ram_idx_s];
      end else if (is_data_s) begin
         rd_next_s = rx_head_s;
      end else if (is_stat_s) begin
         rd_next_s = pack_status(tx_ovf_r, rx_nonempty_s, io_buffer_full);
      end else begin
         rd_next_s = 8'h00;
      end
   end

   // Registered read data; held through write cycles and rdy-low cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_rdata <= 8'h00;
      end else if (rd_cyc_s) begin
         bus_rdata <= rd_next_s;
      end
   end

   // Sticky TX overflow: set on a dropped push, cleared by a status write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_ovf_r <= 1'b0;
      end else if (tx_drop_s) begin
         tx_ovf_r <= 1'b1;
      end else if (wr_cyc_s && is_stat_s) begin
         tx_ovf_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed + randomized bench for mem_responder with a
// queue-based reference model. Follows MEM_RESPONDER_RX_EN for RX checks.
module tb_mem_responder;

`ifdef MEM_RESPONDER_RX_EN
   localparam bit RX_EN = 1'b1;
`else
   localparam bit RX_EN = 1'b0;
`endif

   localparam logic [17:0] A_DATA  = 18'h30000;
   localparam logic [17:0] A_STAT  = 18'h30004;
   localparam logic [17:0] A_OTHER = 18'h30008;
   localparam logic [17:0] A_RAM   = 18'h00123;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic [31:0] bus_addr;
   logic        bus_wr;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   always #5 clk = ~clk;

   mem_responder dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .bus_addr       (bus_addr),
      .bus_wr         (bus_wr),
      .bus_wdata      (bus_wdata),
      .bus_rdata      (bus_rdata),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready)
   );

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   logic [7:0] ram_m [int];
   logic       ovf_m;
   logic [7:0] rdata_m;
   logic [17:0] pool [8];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   // One clock edge of the behavioural model
   task automatic model_edge(input logic r, input logic w, input logic [17:0] a,
                             input logic [7:0] wd, input logic txr,
                             input logic rxv, input logic [7:0] rxd);
      int         txn;
      int         rxn;
      logic       tx_pop;
      logic       rx_push;
      logic [7:0] stat;
      txn  = txq.size();
      rxn  = rxq.size();
      stat = {5'b00000, ovf_m, (RX_EN && rxn > 0), (txn >= 7)};
      if (r) begin
         tx_pop  = (txn > 0) && txr;
         rx_push = rxv && RX_EN && (rxn < 4);
         if (tx_pop) void'(txq.pop_front());
         if (w) begin
            if (a[17:16] != 2'b11) ram_m[int'(a[16:0])] = wd;
            else if (a == A_DATA) begin
               if (txn < 8 || tx_pop) txq.push_back(wd);
               else ovf_m = 1'b1;
            end
            else if (a == A_STAT) ovf_m = 1'b0;
         end else begin
            if (a[17:16] != 2'b11) rdata_m = ram_m[int'(a[16:0])];
            else if (a == A_DATA) rdata_m = (RX_EN && rxn > 0) ? rxq.pop_front() : 8'h00;
            else if (a == A_STAT) rdata_m = stat;
            else rdata_m = 8'h00;
         end
         if (rx_push) rxq.push_back(rxd);
      end
   endtask

   task automatic check_all();
      chk("bus_rdata", bus_rdata, rdata_m);
      chk1("tx_valid", tx_valid, txq.size() != 0);
      if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
      chk1("io_buffer_full", io_buffer_full, txq.size() >= 7);
      chk1("rx_ready", rx_ready, RX_EN && (rxq.size() < 4));
   endtask

   // Drive one bus cycle, clock it, then compare against the model
   task automatic cycle(input logic r, input logic w, input logic [17:0] a,
                        input logic [7:0] wd, input logic txr,
                        input logic rxv, input logic [7:0] rxd);
      rdy       = r;
      bus_wr    = w;
      bus_addr  = {14'($urandom), a};
      bus_wdata = wd;
      tx_ready  = txr;
      rx_valid  = rxv;
      rx_data   = rxd;
      @(posedge clk);
      #1;
      model_edge(r, w, a, wd, txr, rxv, rxd);
      check_all();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         op;
      logic       r;
      logic [17:0] a;
      rst = 1'b0; rdy = 1'b0; bus_addr = 32'h0; bus_wr = 1'b0; bus_wdata = 8'h00;
      tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
      ovf_m = 1'b0; rdata_m = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rdata", bus_rdata, 8'h00);
      chk1("reset_tx_valid", tx_valid, 1'b0);
      chk1("reset_io_full", io_buffer_full, 1'b0);
      chk1("reset_rx_ready", rx_ready, RX_EN);
      rst = 1'b1;

      // RAM write then read: data visible one cycle after the read address
      cycle(1'b1, 1'b1, A_RAM, 8'hA5, 1'b0, 1'b0, 8'h00);
      chk("ram_before_read", bus_rdata, 8'h00);
      cycle(1'b1, 1'b0, A_RAM, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("ram_read_a5", bus_rdata, 8'hA5);

      // TX fill with back-pressure, overflow and drop
      for (int i = 1; i <= 9; i++) begin
         cycle(1'b1, 1'b1, A_DATA, 8'(i), 1'b0, 1'b0, 8'h00);
         if (i == 6) chk1("io_full_after6", io_buffer_full, 1'b0);
         if (i == 7) chk1("io_full_after7", io_buffer_full, 1'b1);
      end
      cycle(1'b1, 1'b0, A_STAT, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("status_ovf", bus_rdata, 8'h05);

      // rdy low: nothing may change
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, A_DATA, 8'h77, 1'b1, 1'b1, 8'h99);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, A_RAM, 8'h5A, 1'b1, 1'b1, 8'h99);
      chk("rdy_low_rdata_held", bus_rdata, 8'h05);
      cycle(1'b1, 1'b0, A_RAM, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("rdy_low_ram_kept", bus_rdata, 8'hA5);

      // Drain TX and verify order
      for (int i = 0; i < 8; i++) begin
         chk("tx_seq", tx_data, 8'(i + 1));
         cycle(1'b1, 1'b0, A_OTHER, 8'h00, 1'b1, 1'b0, 8'h00);
      end
      chk1("tx_drained", tx_valid, 1'b0);
      cycle(1'b1, 1'b1, A_STAT, 8'hFF, 1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, A_STAT, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("status_cleared", bus_rdata, 8'h00);

`ifdef MEM_RESPONDER_RX_EN
      cycle(1'b1, 1'b0, A_OTHER, 8'h00, 1'b0, 1'b1, 8'h41);
      cycle(1'b1, 1'b0, A_OTHER, 8'h00, 1'b0, 1'b1, 8'h42);
      cycle(1'b1, 1'b0, A_DATA, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("rx_pop_41", bus_rdata, 8'h41);
      cycle(1'b1, 1'b0, A_STAT, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("rx_stat_nonempty", bus_rdata, 8'h02);
      cycle(1'b1, 1'b0, A_DATA, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("rx_pop_42", bus_rdata, 8'h42);
      cycle(1'b1, 1'b0, A_STAT, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("rx_stat_empty", bus_rdata, 8'h00);
      cycle(1'b1, 1'b0, A_DATA, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("rx_pop_empty", bus_rdata, 8'h00);
`else
      cycle(1'b1, 1'b0, A_RAM, 8'h00, 1'b0, 1'b1, 8'h41);
      chk1("rx_ready_off", rx_ready, 1'b0);
      cycle(1'b1, 1'b0, A_DATA, 8'h00, 1'b0, 1'b1, 8'h42);
      chk("rx_read_off", bus_rdata, 8'h00);
      cycle(1'b1, 1'b0, A_STAT, 8'h00, 1'b0, 1'b1, 8'h43);
      chk("rx_stat_off", bus_rdata, 8'h00);
`endif

      // Seed a RAM pool for random reads
      for (int i = 0; i < 8; i++) begin
         pool[i] = 18'(32'h01000 + i * 32'h00111);
         cycle(1'b1, 1'b1, pool[i], 8'($urandom), 1'b0, 1'b0, 8'h00);
      end

      // Randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         op = int'($urandom_range(0, 9));
         r  = ($urandom_range(0, 7) != 0);
         a  = {2'b11, 16'($urandom)};
         if (a == A_DATA || a == A_STAT) a = 18'h3FFFF;
         case (op)
            0, 1: cycle(r, 1'b1, pool[$urandom_range(0, 7)], 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            2, 3: cycle(r, 1'b0, pool[$urandom_range(0, 7)], 8'h00, 1'($urandom), 1'($urandom), 8'($urandom));
            4:    cycle(r, 1'b1, A_DATA, 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            5:    cycle(r, 1'b0, A_DATA, 8'h00, 1'($urandom), 1'($urandom), 8'($urandom));
            6:    cycle(r, 1'b0, A_STAT, 8'h00, 1'($urandom), 1'($urandom), 8'($urandom));
            7:    cycle(r, 1'b1, A_STAT, 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            8:    cycle(r, 1'b1, a, 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            default: cycle(r, 1'b0, a, 8'h00, 1'($urandom), 1'($urandom), 8'($urandom));
         endcase
      end

      // Mid-stream asynchronous reset with 3 TX bytes queued
      for (int i = 0; i < 20 && txq.size() > 0; i++)
         cycle(1'b1, 1'b0, A_OTHER, 8'h00, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, A_DATA, 8'(8'hC0 + i), 1'b0, 1'b0, 8'h00);
      chk1("queued_before_rst", tx_valid, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk1("async_rst_tx_valid", tx_valid, 1'b0);
      chk1("async_rst_io_full", io_buffer_full, 1'b0);
      chk("async_rst_rdata", bus_rdata, 8'h00);
      txq.delete(); rxq.delete(); ovf_m = 1'b0; rdata_m = 8'h00;
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b1;
      cycle(1'b1, 1'b0, A_RAM, 8'h00, 1'b0, 1'b0, 8'h00);
      chk("ram_survives_rst", bus_rdata, 8'hA5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
